// File: rtl/seq_chunk_adder_if.sv
`default_nettype none
// ============================================================
// Module : seq_chunk_adder_if
// Brief  : request/result bundle for the chunked adder
// Rev    : 1.0
// ============================================================
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/seq_chunk_adder.sv
`default_nettype none
// ============================================================
// Module : seq_chunk_adder
// Brief  : multi-cycle add/subtract, CHUNK bits per clock, LSB first
// Rev    : 1.0
// ============================================================
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst,
  seq_chunk_adder_if.slave   bus
);

  localparam int c_NCHUNK = WIDTH / CHUNK;
  localparam int c_IDXW   = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
  localparam logic [c_IDXW-1:0] c_LAST = c_IDXW'(c_NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_busy;
  logic              w_done;

  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_carry;
  logic [c_IDXW-1:0] r_idx;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;

  logic [CHUNK-1:0]  w_ca;
  logic [CHUNK-1:0]  w_cb;
  logic [CHUNK-1:0]  w_s;
  logic [CHUNK:0]    w_c;
  logic              w_last;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) w_next = S_RUN;
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_last = (r_idx == c_LAST);
  assign w_ca   = r_a[CHUNK*int'(r_idx) +: CHUNK];
  assign w_cb   = r_b[CHUNK*int'(r_idx) +: CHUNK];
  assign w_c[0] = r_carry;

  for (genvar i = 0; i < CHUNK; i++) begin : g_ripple
    assign w_s[i]   = w_ca[i] ^ w_cb[i] ^ w_c[i];
    assign w_c[i+1] = (w_ca[i] & w_cb[i]) | (w_c[i] & (w_ca[i] ^ w_cb[i]));
  end

  // Subtraction is a + ~b + 1, so the inversion and forced carry happen at latch time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub | bus.cin;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_sum[CHUNK*int'(r_idx) +: CHUNK] <= w_s;
          r_carry <= w_c[CHUNK];
          if (w_last) begin
            r_idx  <= '0;
            r_cout <= w_c[CHUNK];
            r_ovf  <= w_c[CHUNK] ^ w_c[CHUNK-1];
          end else begin
            r_idx  <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
`default_nettype none
// ============================================================
// Module : tb_seq_chunk_adder
// Brief  : randomized scoreboard bench for seq_chunk_adder (16/4)
// Rev    : 1.0
// ============================================================
module tb_seq_chunk_adder;

  localparam int c_W  = 16;
  localparam int c_NC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    logic [c_W-1:0] sum;
    logic           cout;
    logic           ovf;
    int             acc;
  } exp_t;

  exp_t q[$];

  seq_chunk_adder_if #(.WIDTH(c_W)) bus ();

  seq_chunk_adder #(.WIDTH(c_W), .CHUNK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Whole-word reference: subtraction as a + ~b + 1, overflow from operand/result signs.
  function automatic exp_t model(input bit s, input logic [c_W-1:0] av, input logic [c_W-1:0] bv,
                                 input bit ci, input int acc);
    exp_t           m;
    logic [c_W-1:0] bb;
    logic [c_W:0]   r;
    bb     = s ? ~bv : bv;
    r      = {1'b0, av} + {1'b0, bb} + (c_W+1)'(s ? 1'b1 : ci);
    m.sum  = r[c_W-1:0];
    m.cout = r[c_W];
    m.ovf  = (av[c_W-1] == bb[c_W-1]) && (r[c_W-1] != av[c_W-1]);
    m.acc  = acc;
    return m;
  endfunction

  task automatic start_op(input bit s, input logic [c_W-1:0] av, input logic [c_W-1:0] bv, input bit ci);
    int t = 0;
    while ((bus.busy || bus.done) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_wait: got busy=%0b expected busy=0", bus.busy);
    end
    bus.start = 1'b1;
    bus.sub   = s;
    bus.a     = av;
    bus.b     = bv;
    bus.cin   = ci;
    q.push_back(model(s, av, bv, ci, cyc + 1));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Monitor: samples just after each rising edge.
  initial begin : monitor
    exp_t           e;
    int             busy_cnt = 0;
    logic [c_W-1:0] last_sum = '0;
    logic           last_cout = 1'b0;
    logic           last_ovf = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_sum",  bus.sum,  0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_ovf",  bus.ovf,  0);
        last_sum  = '0;
        last_cout = 1'b0;
        last_ovf  = 1'b0;
        busy_cnt  = 0;
      end else begin
        if (bus.busy) busy_cnt++;
        if (bus.done) begin
          chk("done_busy_low", bus.busy, 0);
          if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_done: got done=1 expected done=0 (no op pending)");
          end else begin
            e = q.pop_front();
            chk("sum",        bus.sum,   e.sum);
            chk("cout",       bus.cout,  e.cout);
            chk("ovf",        bus.ovf,   e.ovf);
            chk("latency",    cyc - e.acc, c_NC);
            chk("busy_cycles", busy_cnt, c_NC);
            last_sum  = e.sum;
            last_cout = e.cout;
            last_ovf  = e.ovf;
          end
          busy_cnt = 0;
        end else if (!bus.busy) begin
          chk("hold_sum",  bus.sum,  last_sum);
          chk("hold_cout", bus.cout, last_cout);
          chk("hold_ovf",  bus.ovf,  last_ovf);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : driver
    int t;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    start_op(1'b0, 16'h0001, 16'h0002, 1'b1);
    start_op(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    start_op(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    start_op(1'b1, 16'h8000, 16'h0001, 1'b0);
    start_op(1'b1, 16'h0005, 16'h0007, 1'b1);

    // Second start while running must be dropped.
    start_op(1'b0, 16'd81, 16'd18, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'd35;
    bus.b     = 16'd45;
    @(negedge clk);
    bus.start = 1'b0;

    // Reset lands on the edge closing the third RUN cycle.
    start_op(1'b0, 16'd100, 16'd200, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    start_op(1'b0, 16'd56, 16'd7, 1'b1);

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_op(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
